// File: rtl/posix_alarm_watches_pkg.sv
// Shared constants and types for the POSIX alarm-clock core: day/hour/minute lengths,
// converter and alarm-channel state encodings, and the per-channel alarm setting.
package posix_alarm_pkg;

  localparam int SEC_PER_DAY  = 86400;
  localparam int SEC_PER_HOUR = 3600;
  localparam int SEC_PER_MIN  = 60;

  typedef enum logic [1:0] {
    IDLE,
    RINGING,
    SNOOZED
  } alarm_state_t;

  typedef enum logic [2:0] {
    CONV_IDLE,
    CONV_MOD,
    CONV_HOUR,
    CONV_MINSEC,
    CONV_DONE
  } conv_state_t;

  typedef struct packed {
    logic       en;
    logic [4:0] hour;
    logic [5:0] min;
  } alarm_cfg_t;

endpackage

// File: rtl/posix_alarm_watches_if.sv
// Bundle of user controls and time/alarm outputs exchanged between the core and its
// surroundings (display, buzzer, user panel).
interface posix_alarm_watches_if #(
  parameter int ALARM_CNT = 4
);
  localparam int IDX_W = (ALARM_CNT > 1) ? $clog2(ALARM_CNT) : 1;

  logic [31:0]          user_posix_time_i;
  logic                 user_posix_time_en_i;
  logic                 alarm_wr_en_i;
  logic [IDX_W-1:0]     alarm_idx_i;
  logic                 alarm_en_i;
  logic [4:0]           alarm_hour_i;
  logic [5:0]           alarm_min_i;
  logic                 snooze_i;
  logic                 stop_i;
  logic [31:0]          posix_time_o;
  logic                 new_posix_time_o;
  logic                 tick_o;
  logic                 sec_blnk_o;
  logic [4:0]           hour_o;
  logic [5:0]           min_o;
  logic [5:0]           sec_o;
  logic                 tod_valid_o;
  logic [ALARM_CNT-1:0] ring_o;
  logic                 any_ring_o;

  modport master (
    output user_posix_time_i, user_posix_time_en_i, alarm_wr_en_i, alarm_idx_i,
           alarm_en_i, alarm_hour_i, alarm_min_i, snooze_i, stop_i,
    input  posix_time_o, new_posix_time_o, tick_o, sec_blnk_o, hour_o, min_o, sec_o,
           tod_valid_o, ring_o, any_ring_o
  );

  modport slave (
    input  user_posix_time_i, user_posix_time_en_i, alarm_wr_en_i, alarm_idx_i,
           alarm_en_i, alarm_hour_i, alarm_min_i, snooze_i, stop_i,
    output posix_time_o, new_posix_time_o, tick_o, sec_blnk_o, hour_o, min_o, sec_o,
           tod_valid_o, ring_o, any_ring_o
  );

endinterface

// File: rtl/posix_alarm_watches_tod_conv.sv
// Serial POSIX-to-time-of-day converter: restoring remainder by 86400, then repeated
// subtraction for hours and minutes. A start strobe at any time aborts and restarts.
module posix_tod_conv
  import posix_alarm_pkg::*;
#(
  parameter int GMT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] posix_i,
  output logic        done_o,
  output logic [4:0]  hour_o,
  output logic [5:0]  min_o,
  output logic [5:0]  sec_o
);

  localparam logic [31:0] GMT_OFFSET = 32'(GMT * SEC_PER_HOUR);
  localparam logic [17:0] DAY_18     = 18'(SEC_PER_DAY);
  localparam logic [16:0] HOUR_17    = 17'(SEC_PER_HOUR);
  localparam logic [16:0] HOUR2_17   = 17'(2 * SEC_PER_HOUR);
  localparam logic [16:0] MIN_17     = 17'(SEC_PER_MIN);
  localparam logic [16:0] MIN2_17    = 17'(2 * SEC_PER_MIN);

  conv_state_t state_reg, state_next;
  logic [31:0] dividend_reg, dividend_next;
  logic [16:0] rem_reg, rem_next;
  logic [4:0]  bit_cnt_reg, bit_cnt_next;
  logic [4:0]  hour_reg, hour_next;
  logic [5:0]  min_reg, min_next;
  logic [17:0] shifted;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= CONV_IDLE;
      dividend_reg <= '0;
      rem_reg      <= '0;
      bit_cnt_reg  <= '0;
      hour_reg     <= '0;
      min_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      dividend_reg <= dividend_next;
      rem_reg      <= rem_next;
      bit_cnt_reg  <= bit_cnt_next;
      hour_reg     <= hour_next;
      min_reg      <= min_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    dividend_next = dividend_reg;
    rem_next      = rem_reg;
    bit_cnt_next  = bit_cnt_reg;
    hour_next     = hour_reg;
    min_next      = min_reg;
    done_o        = 1'b0;
    shifted       = {rem_reg, dividend_reg[31]};

    case (state_reg)
      CONV_IDLE: ;
      CONV_MOD: begin
        rem_next      = (shifted >= DAY_18) ? 17'(shifted - DAY_18) : shifted[16:0];
        dividend_next = {dividend_reg[30:0], 1'b0};
        bit_cnt_next  = bit_cnt_reg - 5'd1;
        if (bit_cnt_reg == 5'd0) state_next = CONV_HOUR;
      end
      // Leave as soon as the post-subtraction remainder drops below one unit,
      // so the final subtraction and the state change share a cycle.
      CONV_HOUR: begin
        if (rem_reg >= HOUR_17) begin
          rem_next  = rem_reg - HOUR_17;
          hour_next = hour_reg + 5'd1;
          if (rem_reg < HOUR2_17) state_next = CONV_MINSEC;
        end else begin
          state_next = CONV_MINSEC;
        end
      end
      CONV_MINSEC: begin
        if (rem_reg >= MIN_17) begin
          rem_next = rem_reg - MIN_17;
          min_next = min_reg + 6'd1;
          if (rem_reg < MIN2_17) state_next = CONV_DONE;
        end else begin
          state_next = CONV_DONE;
        end
      end
      CONV_DONE: begin
        done_o     = 1'b1;
        state_next = CONV_IDLE;
      end
      default: state_next = CONV_IDLE;
    endcase

    if (start_i) begin
      state_next    = CONV_MOD;
      dividend_next = posix_i + GMT_OFFSET;
      rem_next      = '0;
      bit_cnt_next  = 5'd31;
      hour_next     = '0;
      min_next      = '0;
    end
  end

  assign hour_o = hour_reg;
  assign min_o  = min_reg;
  assign sec_o  = rem_reg[5:0];

endmodule

// File: rtl/posix_alarm_watches.sv
// Alarm-clock time-keeping core: POSIX counter with 1 Hz prescaler, local time of day
// kept by a serial converter plus tick increments, and ALARM_CNT ring/snooze channels.
module posix_alarm_watches
  import posix_alarm_pkg::*;
#(
  parameter int          CLK_FREQ_HZ      = 25_000_000,
  parameter int          GMT              = 3,
  parameter logic [31:0] START_POSIX_TIME = 32'd0,
  parameter int          ALARM_CNT        = 4,
  parameter int          SNOOZE_SEC       = 300,
  parameter int          RING_MAX_SEC     = 600
) (
  input logic                  clk_i,
  input logic                  rst_i,
  posix_alarm_watches_if.slave bus
);

  localparam int IDX_W   = (ALARM_CNT > 1) ? $clog2(ALARM_CNT) : 1;
  localparam int PRESC_W = $clog2(CLK_FREQ_HZ);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_FREQ_HZ - 1);
  localparam int CNT_MAX = (SNOOZE_SEC > RING_MAX_SEC) ? SNOOZE_SEC : RING_MAX_SEC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SEC);
  localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_MAX_SEC);

  logic [PRESC_W-1:0] presc_reg;
  logic [31:0]        posix_reg;
  logic               new_reg, blnk_reg, tod_valid_reg, init_reg, any_ring_reg;
  logic [4:0]         hour_reg, hour_inc, conv_hour;
  logic [5:0]         min_reg, min_inc, conv_min;
  logic [5:0]         sec_reg, sec_inc, conv_sec;
  logic               tick, load, tod_tick, conv_start, conv_done, sec_wrap, min_wrap;
  logic [31:0]        conv_posix;
  logic [ALARM_CNT-1:0] ring_vec, ring_next_vec;

  assign tick     = (presc_reg == PRESC_LAST);
  assign load     = bus.user_posix_time_en_i;
  assign tod_tick = tick && tod_valid_reg && !load;

  // init_reg kicks off the conversion of START_POSIX_TIME right after reset.
  assign conv_start = init_reg || load;
  assign conv_posix = load ? bus.user_posix_time_i : posix_reg;

  posix_tod_conv #(.GMT(GMT)) u_conv (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (conv_start),
    .posix_i (conv_posix),
    .done_o  (conv_done),
    .hour_o  (conv_hour),
    .min_o   (conv_min),
    .sec_o   (conv_sec)
  );

  always_comb begin
    sec_wrap = (sec_reg == 6'd59);
    min_wrap = (min_reg == 6'd59);
    sec_inc  = sec_wrap ? 6'd0 : sec_reg + 6'd1;
    min_inc  = min_reg;
    hour_inc = hour_reg;
    if (sec_wrap) min_inc = min_wrap ? 6'd0 : min_reg + 6'd1;
    if (sec_wrap && min_wrap) hour_inc = (hour_reg == 5'd23) ? 5'd0 : hour_reg + 5'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_reg     <= '0;
      posix_reg     <= START_POSIX_TIME;
      new_reg       <= 1'b0;
      blnk_reg      <= 1'b0;
      tod_valid_reg <= 1'b0;
      init_reg      <= 1'b1;
      hour_reg      <= '0;
      min_reg       <= '0;
      sec_reg       <= '0;
      any_ring_reg  <= 1'b0;
    end else begin
      init_reg     <= 1'b0;
      new_reg      <= load || tick;
      any_ring_reg <= |ring_next_vec;
      if (tick) blnk_reg <= ~blnk_reg;
      // A load on the tick cycle wins: the increment is dropped.
      if (load) begin
        posix_reg <= bus.user_posix_time_i;
        presc_reg <= '0;
      end else begin
        presc_reg <= tick ? '0 : presc_reg + PRESC_W'(1);
        if (tick) posix_reg <= posix_reg + 32'd1;
      end
      if (load) begin
        tod_valid_reg <= 1'b0;
      end else if (conv_done) begin
        tod_valid_reg <= 1'b1;
        hour_reg      <= conv_hour;
        min_reg       <= conv_min;
        sec_reg       <= conv_sec;
      end else if (tod_tick) begin
        hour_reg <= hour_inc;
        min_reg  <= min_inc;
        sec_reg  <= sec_inc;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ALARM_CNT; gi++) begin : g_ch
      alarm_cfg_t   cfg_reg;
      alarm_state_t state_reg, state_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic wr_hit, hit;

      // Out-of-range indices never match any channel and are thus ignored.
      assign wr_hit = bus.alarm_wr_en_i && (bus.alarm_idx_i == IDX_W'(gi));
      assign hit    = cfg_reg.en && tod_tick && (sec_inc == 6'd0) &&
                      (min_inc == cfg_reg.min) && (hour_inc == cfg_reg.hour);

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          cfg_reg   <= '0;
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          if (wr_hit) cfg_reg <= {bus.alarm_en_i, bus.alarm_hour_i, bus.alarm_min_i};
        end
      end

      // cnt_reg holds ring timeout while RINGING and snooze time while SNOOZED.
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
          IDLE: begin
            if (hit) begin
              state_next = RINGING;
              cnt_next   = RING_LOAD;
            end
          end
          RINGING: begin
            if (bus.stop_i) begin
              state_next = IDLE;
            end else if (bus.snooze_i) begin
              state_next = SNOOZED;
              cnt_next   = SNOOZE_LOAD;
            end else if (tick) begin
              if (cnt_reg <= CNT_W'(1)) state_next = IDLE;
              else cnt_next = cnt_reg - CNT_W'(1);
            end
          end
          SNOOZED: begin
            if (bus.stop_i) begin
              state_next = IDLE;
            end else if (tick) begin
              if (cnt_reg <= CNT_W'(1)) begin
                state_next = RINGING;
                cnt_next   = RING_LOAD;
              end else begin
                cnt_next = cnt_reg - CNT_W'(1);
              end
            end
          end
          default: state_next = IDLE;
        endcase
        if (wr_hit && !bus.alarm_en_i) state_next = IDLE;
      end

      assign ring_vec[gi]      = (state_reg == RINGING);
      assign ring_next_vec[gi] = (state_next == RINGING);
    end
  endgenerate

  assign bus.posix_time_o     = posix_reg;
  assign bus.new_posix_time_o = new_reg;
  assign bus.tick_o           = tick;
  assign bus.sec_blnk_o       = blnk_reg;
  assign bus.hour_o           = hour_reg;
  assign bus.min_o            = min_reg;
  assign bus.sec_o            = sec_reg;
  assign bus.tod_valid_o      = tod_valid_reg;
  assign bus.ring_o           = ring_vec;
  assign bus.any_ring_o       = any_ring_reg;

endmodule

// File: tb/tb_posix_alarm_watches.sv
// Directed bench: dut_a (GMT=3) covers reset/startup conversion, dut_b (GMT=0) covers
// loads, rollover and the alarm channels, with 128 clocks per second.
module tb_posix_alarm_watches;

  logic clk, rst;
  int   checks, fails, cyc;

  posix_alarm_watches_if #(.ALARM_CNT(4)) ifa ();
  posix_alarm_watches_if #(.ALARM_CNT(4)) ifb ();

  posix_alarm_watches #(
    .CLK_FREQ_HZ(128), .GMT(3), .START_POSIX_TIME(32'd0),
    .ALARM_CNT(4), .SNOOZE_SEC(3), .RING_MAX_SEC(5)
  ) dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));

  posix_alarm_watches #(
    .CLK_FREQ_HZ(128), .GMT(0), .START_POSIX_TIME(32'd0),
    .ALARM_CNT(4), .SNOOZE_SEC(3), .RING_MAX_SEC(5)
  ) dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ifa.user_posix_time_i = '0; ifa.user_posix_time_en_i = 0; ifa.alarm_wr_en_i = 0;
    ifa.alarm_idx_i = '0; ifa.alarm_en_i = 0; ifa.alarm_hour_i = '0; ifa.alarm_min_i = '0;
    ifa.snooze_i = 0; ifa.stop_i = 0;
    ifb.user_posix_time_i = '0; ifb.user_posix_time_en_i = 0; ifb.alarm_wr_en_i = 0;
    ifb.alarm_idx_i = '0; ifb.alarm_en_i = 0; ifb.alarm_hour_i = '0; ifb.alarm_min_i = '0;
    ifb.snooze_i = 0; ifb.stop_i = 0;
  endtask

  task automatic load_time(input logic [31:0] v);
    ifb.user_posix_time_i    = v;
    ifb.user_posix_time_en_i = 1'b1;
    step();
    ifb.user_posix_time_en_i = 1'b0;
    $display("load posix=%0d at cycle %0d", v, cyc);
  endtask

  task automatic write_alarm(input logic [1:0] idx, input logic en,
                             input logic [4:0] h, input logic [5:0] m);
    ifb.alarm_idx_i   = idx;
    ifb.alarm_en_i    = en;
    ifb.alarm_hour_i  = h;
    ifb.alarm_min_i   = m;
    ifb.alarm_wr_en_i = 1'b1;
    step();
    ifb.alarm_wr_en_i = 1'b0;
    $display("alarm write ch%0d en=%0b %0d:%0d", idx, en, h, m);
  endtask

  task automatic wait_tick();
    int n = 0;
    while (!ifb.tick_o && n < 300) begin step(); n++; end
    checks++;
    if (ifb.tick_o !== 1'b1) begin
      fails++; $display("FAIL wait_tick: tick_o=%b, required 1 within 300 cycles", ifb.tick_o);
    end
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!ifb.tod_valid_o && n < 116) begin step(); n++; end
    checks++;
    if (ifb.tod_valid_o !== 1'b1) begin
      fails++; $display("FAIL wait_valid: tod_valid_o=%b, required 1 within 116 cycles", ifb.tod_valid_o);
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ifa.posix_time_o !== 32'd0 || ifb.posix_time_o !== 32'd0) begin
      fails++; $display("FAIL reset_posix: got %0d/%0d, required 0", ifa.posix_time_o, ifb.posix_time_o);
    end
    checks++;
    if ({ifa.tick_o, ifa.new_posix_time_o, ifa.sec_blnk_o, ifa.tod_valid_o} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: tick/new/blnk/valid=%b, required 0000",
                        {ifa.tick_o, ifa.new_posix_time_o, ifa.sec_blnk_o, ifa.tod_valid_o});
    end
    checks++;
    if ({ifa.hour_o, ifa.min_o, ifa.sec_o} !== 17'd0 || {ifa.ring_o, ifa.any_ring_o} !== 5'd0) begin
      fails++; $display("FAIL reset_tod_ring: got %0d:%0d:%0d ring=%b, required 0:0:0 ring=0",
                        ifa.hour_o, ifa.min_o, ifa.sec_o, ifa.ring_o);
    end
    rst = 1'b0;
    n = 0;
    while (!ifa.tod_valid_o && n < 116) begin step(); n++; end
    checks++;
    if (ifa.tod_valid_o !== 1'b1) begin
      fails++; $display("FAIL reset_conv_latency: tod_valid_o=%b after %0d cycles, required 1 within 116", ifa.tod_valid_o, cyc);
    end
    checks++;
    if ({ifa.hour_o, ifa.min_o, ifa.sec_o} !== {5'd3, 6'd0, 6'd0}) begin
      fails++; $display("FAIL reset_tod: got %0d:%0d:%0d, required 3:0:0", ifa.hour_o, ifa.min_o, ifa.sec_o);
    end
    n = 0;
    while (!ifa.tick_o && n < 200) begin step(); n++; end
    checks++;
    if (ifa.tick_o !== 1'b1 || ifa.posix_time_o !== 32'd0) begin
      fails++; $display("FAIL first_tick: tick=%b posix=%0d, required tick=1 posix=0", ifa.tick_o, ifa.posix_time_o);
    end
    step();
    checks++;
    if (cyc !== 128 || ifa.posix_time_o !== 32'd1 || ifa.new_posix_time_o !== 1'b1 || ifa.tick_o !== 1'b0) begin
      fails++; $display("FAIL tick_increment: cycle=%0d posix=%0d new=%b tick=%b, required 128/1/1/0",
                        cyc, ifa.posix_time_o, ifa.new_posix_time_o, ifa.tick_o);
    end
    checks++;
    if ({ifa.hour_o, ifa.min_o, ifa.sec_o} !== {5'd3, 6'd0, 6'd1}) begin
      fails++; $display("FAIL tick_tod: got %0d:%0d:%0d, required 3:0:1", ifa.hour_o, ifa.min_o, ifa.sec_o);
    end
    $display("reset test done at cycle %0d", cyc);
  endtask

  task automatic test_load();
    load_time(32'd1700000000);
    checks++;
    if (ifb.posix_time_o !== 32'd1700000000 || ifb.new_posix_time_o !== 1'b1 || ifb.tod_valid_o !== 1'b0) begin
      fails++; $display("FAIL load: posix=%0d new=%b valid=%b, required 1700000000/1/0",
                        ifb.posix_time_o, ifb.new_posix_time_o, ifb.tod_valid_o);
    end
    wait_valid();
    checks++;
    if ({ifb.hour_o, ifb.min_o, ifb.sec_o} !== {5'd22, 6'd13, 6'd20}) begin
      fails++; $display("FAIL load_tod: got %0d:%0d:%0d, required 22:13:20", ifb.hour_o, ifb.min_o, ifb.sec_o);
    end
    wait_tick();
    load_time(32'd1700000100);
    checks++;
    if (ifb.posix_time_o !== 32'd1700000100 || ifb.tod_valid_o !== 1'b0 || ifb.new_posix_time_o !== 1'b1) begin
      fails++; $display("FAIL load_on_tick: posix=%0d valid=%b new=%b, required 1700000100/0/1",
                        ifb.posix_time_o, ifb.tod_valid_o, ifb.new_posix_time_o);
    end
    wait_valid();
    checks++;
    if ({ifb.hour_o, ifb.min_o, ifb.sec_o} !== {5'd22, 6'd15, 6'd0}) begin
      fails++; $display("FAIL load_on_tick_tod: got %0d:%0d:%0d, required 22:15:0", ifb.hour_o, ifb.min_o, ifb.sec_o);
    end
  endtask

  task automatic test_rollover();
    logic b0;
    load_time(32'd86399);
    wait_valid();
    checks++;
    if ({ifb.hour_o, ifb.min_o, ifb.sec_o} !== {5'd23, 6'd59, 6'd59}) begin
      fails++; $display("FAIL rollover_load: got %0d:%0d:%0d, required 23:59:59", ifb.hour_o, ifb.min_o, ifb.sec_o);
    end
    wait_tick();
    b0 = ifb.sec_blnk_o;
    step();
    checks++;
    if ({ifb.hour_o, ifb.min_o, ifb.sec_o} !== 17'd0 || ifb.posix_time_o !== 32'd86400 || ifb.sec_blnk_o !== ~b0) begin
      fails++; $display("FAIL rollover_tick: got %0d:%0d:%0d posix=%0d blnk=%b, required 0:0:0 86400 blnk=%b",
                        ifb.hour_o, ifb.min_o, ifb.sec_o, ifb.posix_time_o, ifb.sec_blnk_o, ~b0);
    end
    wait_tick();
    step();
    checks++;
    if ({ifb.hour_o, ifb.min_o, ifb.sec_o} !== {5'd0, 6'd0, 6'd1} || ifb.posix_time_o !== 32'd86401 || ifb.sec_blnk_o !== b0) begin
      fails++; $display("FAIL rollover_tick2: got %0d:%0d:%0d posix=%0d blnk=%b, required 0:0:1 86401 blnk=%b",
                        ifb.hour_o, ifb.min_o, ifb.sec_o, ifb.posix_time_o, ifb.sec_blnk_o, b0);
    end
  endtask

  task automatic test_alarm_ring();
    write_alarm(2'd1, 1'b1, 5'd7, 6'd0);
    write_alarm(2'd2, 1'b0, 5'd7, 6'd0);
    write_alarm(2'd3, 1'b1, 5'd7, 6'd1);
    load_time(32'd25198);
    wait_valid();
    checks++;
    if ({ifb.hour_o, ifb.min_o, ifb.sec_o} !== {5'd6, 6'd59, 6'd58} || ifb.ring_o !== 4'b0000) begin
      fails++; $display("FAIL alarm_pre: got %0d:%0d:%0d ring=%b, required 6:59:58 ring=0000",
                        ifb.hour_o, ifb.min_o, ifb.sec_o, ifb.ring_o);
    end
    wait_tick();
    step();
    checks++;
    if (ifb.sec_o !== 6'd59 || ifb.ring_o !== 4'b0000 || ifb.any_ring_o !== 1'b0) begin
      fails++; $display("FAIL alarm_early: sec=%0d ring=%b any=%b, required 59/0000/0", ifb.sec_o, ifb.ring_o, ifb.any_ring_o);
    end
    wait_tick();
    step();
    checks++;
    if ({ifb.hour_o, ifb.min_o, ifb.sec_o} !== {5'd7, 6'd0, 6'd0} || ifb.ring_o !== 4'b0010 || ifb.any_ring_o !== 1'b1) begin
      fails++; $display("FAIL alarm_ring: got %0d:%0d:%0d ring=%b any=%b, required 7:0:0 ring=0010 any=1",
                        ifb.hour_o, ifb.min_o, ifb.sec_o, ifb.ring_o, ifb.any_ring_o);
    end
  endtask

  task automatic test_snooze_stop();
    ifb.snooze_i = 1'b1;
    step();
    ifb.snooze_i = 1'b0;
    $display("snooze at cycle %0d", cyc);
    checks++;
    if (ifb.ring_o !== 4'b0000 || ifb.any_ring_o !== 1'b0) begin
      fails++; $display("FAIL snooze: ring=%b any=%b, required 0000/0", ifb.ring_o, ifb.any_ring_o);
    end
    for (int k = 1; k <= 3; k++) begin
      wait_tick();
      step();
      checks++;
      if (ifb.ring_o !== ((k < 3) ? 4'b0000 : 4'b0010)) begin
        fails++; $display("FAIL snooze_tick%0d: ring=%b, required %b", k, ifb.ring_o, (k < 3) ? 4'b0000 : 4'b0010);
      end
    end
    ifb.snooze_i = 1'b1;
    ifb.stop_i   = 1'b1;
    step();
    ifb.snooze_i = 1'b0;
    ifb.stop_i   = 1'b0;
    $display("stop+snooze at cycle %0d", cyc);
    checks++;
    if (ifb.ring_o !== 4'b0000) begin
      fails++; $display("FAIL stop_snooze: ring=%b, required 0000", ifb.ring_o);
    end
    for (int k = 1; k <= 4; k++) begin
      wait_tick();
      step();
      checks++;
      if (ifb.ring_o !== 4'b0000) begin
        fails++; $display("FAIL stop_no_rering%0d: ring=%b, required 0000", k, ifb.ring_o);
      end
    end
  endtask

  task automatic test_ring_timeout();
    load_time(32'd25199);
    wait_valid();
    wait_tick();
    step();
    checks++;
    if (ifb.ring_o !== 4'b0010) begin
      fails++; $display("FAIL timeout_start: ring=%b, required 0010", ifb.ring_o);
    end
    for (int k = 1; k <= 5; k++) begin
      wait_tick();
      step();
      checks++;
      if (ifb.ring_o !== ((k < 5) ? 4'b0010 : 4'b0000)) begin
        fails++; $display("FAIL timeout_tick%0d: ring=%b, required %b", k, ifb.ring_o, (k < 5) ? 4'b0010 : 4'b0000);
      end
    end
  endtask

  task automatic test_disable();
    load_time(32'd25199);
    wait_valid();
    wait_tick();
    step();
    checks++;
    if (ifb.ring_o !== 4'b0010) begin
      fails++; $display("FAIL disable_start: ring=%b, required 0010", ifb.ring_o);
    end
    write_alarm(2'd1, 1'b0, 5'd7, 6'd0);
    checks++;
    if (ifb.ring_o !== 4'b0000 || ifb.any_ring_o !== 1'b0) begin
      fails++; $display("FAIL disable: ring=%b any=%b, required 0000/0", ifb.ring_o, ifb.any_ring_o);
    end
  endtask

  task automatic test_reset_mid_ring();
    write_alarm(2'd1, 1'b1, 5'd7, 6'd0);
    load_time(32'd25199);
    wait_valid();
    wait_tick();
    step();
    checks++;
    if (ifb.ring_o !== 4'b0010) begin
      fails++; $display("FAIL midring_start: ring=%b, required 0010", ifb.ring_o);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ifb.ring_o !== 4'b0000 || ifb.any_ring_o !== 1'b0 || ifb.posix_time_o !== 32'd0) begin
      fails++; $display("FAIL async_reset: ring=%b any=%b posix=%0d, required 0000/0/0",
                        ifb.ring_o, ifb.any_ring_o, ifb.posix_time_o);
    end
    $display("async reset asserted mid-ring");
    step();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_load();
    test_rollover();
    test_alarm_ring();
    test_snooze_stop();
    test_ring_timeout();
    test_disable();
    test_reset_mid_ring();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/posix_alarm_watches.md
Name: posix_alarm_watches

Overview:
- Next-generation time-keeping core for the alarm clock.
- Keeps POSIX time with a built-in 1 Hz prescaler, and derives local hour/min/sec through a sequential loader that converts a POSIX value into a time of day.
- Adds ALARM_CNT independently programmable alarm channels, each with ring, snooze and timeout behaviour.
- Feeds the display and buzzer logic.

Parameters:
- CLK_FREQ_HZ, 25_000_000, clk_i cycles per second; must be >= 128.
- GMT, 3, signed local offset in hours, range -12..14.
- START_POSIX_TIME, 32'd0, POSIX value loaded at reset.
- ALARM_CNT, 4, number of alarm channels, 1..16.
- SNOOZE_SEC, 300, snooze length in seconds.
- RING_MAX_SEC, 600, auto-stop timeout for a ringing channel, in seconds.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- user_posix_time_i  in  32  POSIX value to load.
- user_posix_time_en_i  in  1  load strobe, one cycle.
- alarm_wr_en_i  in  1  alarm-channel write strobe.
- alarm_idx_i  in  $clog2(ALARM_CNT)  channel to write.
- alarm_en_i  in  1  channel enable to write.
- alarm_hour_i  in  5  alarm hour, 0..23.
- alarm_min_i  in  6  alarm minute, 0..59.
- snooze_i  in  1  snooze pulse, applies to all ringing channels.
- stop_i  in  1  stop pulse, applies to all ringing and snoozed channels.
- posix_time_o  out  32  current POSIX time.
- new_posix_time_o  out  1  one-cycle pulse when posix_time_o changes.
- tick_o  out  1  one-cycle pulse on the last cycle of each second.
- sec_blnk_o  out  1  toggles on every tick.
- hour_o  out  5  local hour.
- min_o  out  6  local minute.
- sec_o  out  6  local second.
- tod_valid_o  out  1  high when hour/min/sec are valid.
- ring_o  out  ALARM_CNT  per-channel ringing flags.
- any_ring_o  out  1  OR of ring_o.

Behaviour:
- Reset values:
  - posix_time_o = START_POSIX_TIME; prescaler = 0.
  - sec_blnk_o, tick_o, new_posix_time_o, tod_valid_o = 0.
  - hour_o, min_o, sec_o = 0.
  - All channels IDLE and disabled; ring_o = 0.
  - A conversion of START_POSIX_TIME starts on the first cycle after reset deasserts.
- Prescaler:
  - Counts 0..CLK_FREQ_HZ-1.
  - tick_o is high while the count equals CLK_FREQ_HZ-1.
  - On that cycle, posix_time_o increments (wrapping at 2^32) on the following edge, and new_posix_time_o pulses in the same cycle the new value appears.
- Local time on a tick:
  - sec_o, min_o and hour_o increment with carries: 59->0 for sec and min, 23->0 for hour.
  - Local time is updated only when tod_valid_o = 1.
- Load:
  - user_posix_time_en_i loads posix_time_o on the next edge, pulses new_posix_time_o, clears the prescaler, drops tod_valid_o and restarts the converter.
  - A load during conversion aborts the current conversion and restarts it.
  - A load coinciding with a tick wins; the increment is discarded.
- Converter FSM: IDLE -> MOD -> HOUR -> MINSEC -> DONE -> IDLE.
  - MOD: computes (posix + GMT*3600, modulo 2^32) mod 86400 using 32-step restoring remainder, one bit per cycle.
  - HOUR: repeatedly subtracts 3600 to produce hour_o.
  - MINSEC: repeatedly subtracts 60 to produce min_o; the remainder is sec_o.
  - DONE: writes hour/min/sec and sets tod_valid_o.
  - Worst-case latency is 116 cycles, so no tick can occur during conversion.
- Alarm write:
  - Writes en/hour/min for the selected channel on the next edge.
  - Writing en = 0 forces that channel to IDLE.
  - alarm_idx_i >= ALARM_CNT is ignored.
- Channel FSM: IDLE, RINGING, SNOOZED.
  - IDLE -> RINGING: channel enabled, tod_valid_o = 1, and a tick produces local hour:min = alarm:00:00. ring_o rises with the new time.
  - RINGING -> SNOOZED on snooze_i; the snooze counter loads SNOOZE_SEC.
  - SNOOZED -> RINGING when the snooze counter reaches 0 on a tick.
  - RINGING -> IDLE on stop_i, or after RING_MAX_SEC ticks spent in RINGING.
  - SNOOZED -> IDLE on stop_i.
  - stop_i and snooze_i in the same cycle: stop wins.
  - A load of new time does not affect channel state.
  - ring_o[i] = (state == RINGING); any_ring_o is registered together with ring_o.

Decomposition:
- Package posix_alarm_pkg holds:
  - SEC_PER_DAY = 86400, SEC_PER_HOUR = 3600, SEC_PER_MIN = 60.
  - Enum typedef alarm_state_t {IDLE, RINGING, SNOOZED}.
  - Enum typedef conv_state_t.
  - Struct alarm_cfg_t {en, hour[4:0], min[5:0]}.
- Sub-module posix_tod_conv implements the serial converter, with a start/abort strobe, a done pulse and hour/min/sec outputs.
- The channel FSMs are generated inline, ALARM_CNT instances.

Test Plan:
- CLK_FREQ_HZ = 128, GMT = 3, reset with START 0 -> tod_valid_o rises within 116 cycles; time reads 03:00:00; after 128 cycles tick_o pulses and the time reads 03:00:01.
- GMT = 0, load 1700000000 -> posix_time_o = 1700000000; tod_valid_o is low, then time reads 22:13:20; a load issued on a tick cycle leaves posix_time_o equal to the loaded value.
- GMT = 0, load 86399 -> 23:59:59; after one tick 00:00:00 and posix_time_o = 86400; sec_blnk_o toggles on each tick.
- Load 25198 (06:59:58), channel 1 set to 07:00 and enabled -> ring_o = 4'b0010 and any_ring_o = 1 together with 07:00:00; channels 0, 2, 3 stay 0.
- SNOOZE_SEC = 3: snooze while channel 1 rings -> ring_o = 0 for 3 ticks, then 4'b0010 again; stop_i with snooze_i in the same cycle -> IDLE, no re-ring.
- RING_MAX_SEC = 5, no user action -> ring_o[1] clears after 5 ticks; writing en = 0 while ringing clears it on the next edge; reset mid-ring -> ring_o = 0 immediately, asynchronously.
